// File: rtl/phyreg_free_list_if.sv
// Map/commit-side bundle of the physical register free list.
// The master drives requests, commits, frees and flush; the slave (the free list) answers.
interface phyreg_free_list_if #(
  parameter int PHY_RF_DEPTH = 128,
  parameter int ALLOC_MAX    = 3
);
  localparam int TW = $clog2(PHY_RF_DEPTH);

  logic                          ready;
  logic [1:0]                    alloc_num;
  logic                          alloc_gnt;
  logic [ALLOC_MAX-1:0][TW-1:0]  alloc_tag;
  logic [1:0]                    commit_num;
  logic                          free_en;
  logic [TW-1:0]                 free_tag;
  logic                          flush;
  logic [TW-1:0]                 free_count;
  logic                          low;
  logic                          err;

  modport master (
    input  ready, alloc_gnt, alloc_tag, free_count, low, err,
    output alloc_num, commit_num, free_en, free_tag, flush
  );

  modport slave (
    output ready, alloc_gnt, alloc_tag, free_count, low, err,
    input  alloc_num, commit_num, free_en, free_tag, flush
  );
endinterface

// File: rtl/phyreg_free_list.sv
// Circular free list of physical register tags with speculative/committed heads for one-cycle flush.
// Define FREE_LIST_DOUBLE_FREE_CHECK_EN to add an in-list bitmap that rejects duplicate frees.
module phyreg_free_list #(
  parameter int PHY_RF_DEPTH = 128,
  parameter int ALLOC_MAX    = 3
) (
  input  logic                clk,
  input  logic                rst,
  phyreg_free_list_if.slave   bus
);
  localparam int TW = $clog2(PHY_RF_DEPTH);
  localparam int PW = TW + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [PW-1:0] FULL_SPAN = PW'(PHY_RF_DEPTH - 1);
  localparam logic [PW-1:0] INIT_LAST = PW'(PHY_RF_DEPTH - 2);

  logic [0:0]    state;
  logic [PW-1:0] spec_head;
  logic [PW-1:0] commit_head;
  logic [PW-1:0] tail;
  logic          err_q;
  logic [TW-1:0] ring [PHY_RF_DEPTH];

  logic                         running;
  logic                         init_wr;
  logic [PW-1:0]                req;
  logic [PW-1:0]                avail;
  logic [PW-1:0]                outstanding;
  logic                         gnt;
  logic [ALLOC_MAX-1:0][TW-1:0] tags;
  logic                         commit_bad;
  logic [PW-1:0]                commit_head_nx;
  logic [PW-1:0]                spec_head_nx;
  logic                         dup;
  logic                         free_ok;
  logic                         free_bad;
  logic                         ring_we;
  logic [TW-1:0]                ring_wdata;

  assign running = (state == ST_RUN);
  assign init_wr = (state == ST_INIT);

  // Pointer arithmetic on the extra wrap bit keeps these differences exact.
  assign req         = PW'(bus.alloc_num);
  assign avail       = tail - spec_head;
  assign outstanding = spec_head - commit_head;

  assign gnt = running && !bus.flush && (bus.alloc_num != 2'd0) && (avail >= req);

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    tags = '0;
    for (int k = 0; k < ALLOC_MAX; k++) begin
      if (gnt && (k < int'(bus.alloc_num))) begin
        tags[k] = ring[spec_head[TW-1:0] + TW'(k)];
      end
    end
  end

  assign commit_bad     = running && (PW'(bus.commit_num) > outstanding);
  assign commit_head_nx = (running && !commit_bad) ? commit_head + PW'(bus.commit_num)
                                                   : commit_head;

  always_comb begin
    spec_head_nx = spec_head;
    if (bus.flush) begin
      spec_head_nx = commit_head_nx;
    end else if (gnt) begin
      spec_head_nx = spec_head + req;
    end
  end

  assign free_ok  = running && bus.free_en && (bus.free_tag != '0)
                    && ((tail - commit_head) != FULL_SPAN) && !dup;
  assign free_bad = running && bus.free_en && !free_ok;

  assign ring_we    = init_wr || free_ok;
  assign ring_wdata = init_wr ? (tail[TW-1:0] + TW'(1)) : bus.free_tag;

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [PHY_RF_DEPTH-1:0] in_list;
  logic [PHY_RF_DEPTH-1:0] in_list_nx;
  logic [PW-1:0]           roll;

  assign dup  = in_list[bus.free_tag];
  assign roll = spec_head - commit_head_nx;

  always_comb begin
    in_list_nx = in_list;
    for (int k = 0; k < ALLOC_MAX; k++) begin
      if (gnt && (k < int'(bus.alloc_num))) begin
        in_list_nx[tags[k]] = 1'b0;
      end
    end
    // Ring slots from the restored head up to the old speculative head hold rolled-back tags.
    if (running && bus.flush) begin
      for (int j = 0; j < PHY_RF_DEPTH; j++) begin
        if (PW'(TW'(TW'(j) - commit_head_nx[TW-1:0])) < roll) begin
          in_list_nx[ring[j]] = 1'b1;
        end
      end
    end
    if (ring_we) begin
      in_list_nx[ring_wdata] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_list <= '0;
    end else begin
      in_list <= in_list_nx;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= '0;
      err_q       <= 1'b0;
    end else if (state == ST_INIT) begin
      tail <= tail + PW'(1);
      if (tail == INIT_LAST) begin
        state <= ST_RUN;
      end
    end else begin
      spec_head   <= spec_head_nx;
      commit_head <= commit_head_nx;
      tail        <= tail + PW'(free_ok);
      if (commit_bad || free_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  // NOTE: the ring is a plain memory with no reset; INIT fills every slot that can be read.
  always_ff @(posedge clk) begin
    if (ring_we) begin
      ring[tail[TW-1:0]] <= ring_wdata;
    end
  end

  assign bus.ready      = running;
  assign bus.alloc_gnt  = gnt;
  assign bus.alloc_tag  = tags;
  assign bus.free_count = avail[TW-1:0];
  assign bus.low        = (avail < PW'(ALLOC_MAX));
  assign bus.err        = err_q;
endmodule

// File: tb/tb_phyreg_free_list.sv
// Self-checking bench for phyreg_free_list at PHY_RF_DEPTH=8: table-driven rows through a scoreboard queue.
module tb_phyreg_free_list;
  localparam int DEPTH = 8;
  localparam int AMAX  = 3;

  typedef struct {
    string      name;
    logic [1:0] alloc_num;
    logic [1:0] commit_num;
    logic       free_en;
    logic [2:0] free_tag;
    logic       flush;
    logic       gnt;
    logic [2:0] t0;
    logic [2:0] t1;
    logic [2:0] t2;
    logic [2:0] count;
    logic       low;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  vec_t sb[$];

  phyreg_free_list_if #(.PHY_RF_DEPTH(DEPTH), .ALLOC_MAX(AMAX)) bus ();

  phyreg_free_list #(.PHY_RF_DEPTH(DEPTH), .ALLOC_MAX(AMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int an, input int cn, input int fe,
                              input int ft, input int fl, input int g, input int a, input int b,
                              input int c, input int cnt, input int lo, input int er);
    vec_t v;
    v.name = name;
    v.alloc_num = 2'(an);  v.commit_num = 2'(cn);
    v.free_en = 1'(fe);    v.free_tag = 3'(ft);    v.flush = 1'(fl);
    v.gnt = 1'(g);         v.t0 = 3'(a);  v.t1 = 3'(b);  v.t2 = 3'(c);
    v.count = 3'(cnt);     v.low = 1'(lo);         v.err = 1'(er);
    return v;
  endfunction

  task automatic drive_idle();
    bus.alloc_num  = 2'd0;
    bus.commit_num = 2'd0;
    bus.free_en    = 1'b0;
    bus.free_tag   = 3'd0;
    bus.flush      = 1'b0;
  endtask

  // Each row is one cycle: inputs driven after the edge, outputs compared on the falling edge.
  task automatic run_table();
    vec_t e;
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      bus.alloc_num  = tbl[i].alloc_num;
      bus.commit_num = tbl[i].commit_num;
      bus.free_en    = tbl[i].free_en;
      bus.free_tag   = tbl[i].free_tag;
      bus.flush      = tbl[i].flush;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      check({e.name, ".ready"}, 32'(bus.ready), 32'd1);
      check({e.name, ".gnt"},   32'(bus.alloc_gnt), 32'(e.gnt));
      check({e.name, ".count"}, 32'(bus.free_count), 32'(e.count));
      check({e.name, ".low"},   32'(bus.low), 32'(e.low));
      check({e.name, ".err"},   32'(bus.err), 32'(e.err));
      if (e.gnt) begin
        check({e.name, ".tag0"}, 32'(bus.alloc_tag[0]), 32'(e.t0));
        check({e.name, ".tag1"}, 32'(bus.alloc_tag[1]), 32'(e.t1));
        check({e.name, ".tag2"}, 32'(bus.alloc_tag[2]), 32'(e.t2));
      end
    end
    tbl.delete();
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  // Reset (possibly mid-operation) with a live request, then time the initialisation.
  task automatic reset_and_init(input string name);
    int n;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_idle();
    bus.alloc_num = 2'd3;
    @(posedge clk);
    #1;
    check({name, ".rst_ready"}, 32'(bus.ready), 32'd0);
    check({name, ".rst_gnt"},   32'(bus.alloc_gnt), 32'd0);
    check({name, ".rst_tags"},  32'(bus.alloc_tag), 32'd0);
    check({name, ".rst_count"}, 32'(bus.free_count), 32'd0);
    check({name, ".rst_low"},   32'(bus.low), 32'd1);
    check({name, ".rst_err"},   32'(bus.err), 32'd0);
    rst = 1'b0;
    n = 0;
    while (!bus.ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, ".init_cycles"}, 32'(n), 32'd7);
    bus.alloc_num = 2'd0;
    check({name, ".init_count"}, 32'(bus.free_count), 32'd7);
    check({name, ".init_low"},   32'(bus.low), 32'd0);
  endtask

  initial begin
    drive_idle();

    // A: fill-down allocation, free/alloc in one cycle, bad free with sticky err.
    reset_and_init("A");
    //                 name  an cn fe ft fl  g  t0 t1 t2 cnt lo er
    tbl.push_back(mk("A1",  3, 0, 0, 0, 0, 1, 1, 2, 3, 7, 0, 0));
    tbl.push_back(mk("A2",  3, 3, 0, 0, 0, 1, 4, 5, 6, 4, 0, 0));
    tbl.push_back(mk("A3",  2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk("A4",  1, 0, 1, 5, 0, 1, 7, 0, 0, 1, 1, 0));
    tbl.push_back(mk("A5",  1, 0, 0, 0, 0, 1, 5, 0, 0, 1, 1, 0));
    tbl.push_back(mk("A6",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("A7",  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("A8",  0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("A9",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    run_table();

    // B: mid-operation reset, commit then flush rollback, over-commit, flush with free.
    reset_and_init("B");
    tbl.push_back(mk("B1",  3, 0, 0, 0, 0, 1, 1, 2, 3, 7, 0, 0));
    tbl.push_back(mk("B2",  0, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk("B3",  0, 0, 0, 0, 1, 0, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk("B4",  2, 0, 0, 0, 0, 1, 2, 3, 0, 6, 0, 0));
    tbl.push_back(mk("B5",  0, 3, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk("B6",  1, 2, 0, 0, 0, 1, 4, 0, 0, 4, 0, 1));
    tbl.push_back(mk("B7",  3, 0, 1, 1, 1, 0, 0, 0, 0, 3, 0, 1));
    tbl.push_back(mk("B8",  0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1));
    tbl.push_back(mk("B9",  3, 0, 0, 0, 0, 1, 4, 5, 6, 5, 0, 1));
    run_table();

    // C: free of a tag still sitting in the list.
    reset_and_init("C");
    tbl.push_back(mk("C1",  3, 0, 0, 0, 0, 1, 1, 2, 3, 7, 0, 0));
    tbl.push_back(mk("C2",  0, 3, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk("C3",  0, 0, 1, 7, 0, 0, 0, 0, 0, 4, 0, 0));
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    tbl.push_back(mk("C4",  0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1));
`else
    tbl.push_back(mk("C4",  0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0));
`endif
    run_table();

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
